// File: rtl/vscale_xvec_vstore_seq_if.sv
// Data-memory write-beat bus between the xvec store sequencer (master) and the memory sink (slave).
interface vscale_xvec_vstore_seq_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int XPR_LEN    = 32
);
    logic                  dmem_hvalid;
    logic                  dmem_hwrite;
    logic [ADDR_WIDTH-1:0] dmem_haddr;
    logic [XPR_LEN-1:0]    dmem_hwdata;
    logic                  dmem_hready;

    modport master (
        output dmem_hvalid,
        output dmem_hwrite,
        output dmem_haddr,
        output dmem_hwdata,
        input  dmem_hready
    );

    modport slave (
        input  dmem_hvalid,
        input  dmem_hwrite,
        input  dmem_haddr,
        input  dmem_hwdata,
        output dmem_hready
    );
endinterface

// File: rtl/vscale_xvec_vstore_seq.sv
// xvec vector store sequencer: snapshots a vector operand and emits one write beat per lane.
// Optional per-lane masking is enabled by defining XVEC_VSTORE_MASK_EN.
module vscale_xvec_vstore_seq #(
    parameter int VEC_LEN    = 29,
    parameter int XPR_LEN    = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [XPR_LEN-1:0]         stride,
    input  logic [VEC_LEN*XPR_LEN-1:0] vdata,
`ifdef XVEC_VSTORE_MASK_EN
    input  logic [VEC_LEN-1:0]         lane_mask,
`endif
    output logic                       busy,
    output logic                       done,
    vscale_xvec_vstore_seq_if.master   dmem
);

    localparam int LW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [XPR_LEN-1:0]        wdata_q, wdata_d;

    logic [VEC_LEN*XPR_LEN-1:0] vdata_q;
    logic [ADDR_WIDTH-1:0]      base_q;
    logic signed [XPR_LEN-1:0]  stride_q;

    logic                      capture;
    logic [LW-1:0]             next_idx;
    logic                      last_beat;

    function automatic logic [ADDR_WIDTH-1:0] lane_addr(
        input logic [ADDR_WIDTH-1:0]     base,
        input logic signed [XPR_LEN-1:0] strd,
        input logic [LW-1:0]             lane
    );
        logic [ADDR_WIDTH-1:0] s_ext;
        s_ext = ADDR_WIDTH'(strd);
        return base + ADDR_WIDTH'(lane) * s_ext;
    endfunction

    // Only lanes below VEC_LEN are selectable; out-of-range indices yield zero.
    function automatic logic [XPR_LEN-1:0] lane_word(
        input logic [VEC_LEN*XPR_LEN-1:0] v,
        input logic [LW-1:0]              lane
    );
        logic [XPR_LEN-1:0] w;
        w = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            if (LW'(i) == lane) w = v[i*XPR_LEN +: XPR_LEN];
        end
        return w;
    endfunction

`ifdef XVEC_VSTORE_MASK_EN
    logic [VEC_LEN-1:0] mask_q;
    logic [VEC_LEN-1:0] rem_mask;
    logic [LW-1:0]      first_idx;

    // Lowest set bit wins, giving ascending issue order.
    function automatic logic [LW-1:0] first_lane(input logic [VEC_LEN-1:0] m);
        logic [LW-1:0] idx;
        idx = '0;
        for (int i = VEC_LEN - 1; i >= 0; i--) begin
            if (m[i]) idx = LW'(i);
        end
        return idx;
    endfunction

    function automatic logic [VEC_LEN-1:0] above_lane(input logic [LW-1:0] lane);
        logic [VEC_LEN-1:0] m;
        for (int i = 0; i < VEC_LEN; i++) begin
            m[i] = (i > int'(lane));
        end
        return m;
    endfunction

    assign rem_mask  = mask_q & above_lane(lane_q);
    assign next_idx  = first_lane(rem_mask);
    assign last_beat = ~|rem_mask;
    assign first_idx = first_lane(lane_mask);
`else
    assign next_idx  = lane_q + LW'(1);
    assign last_beat = (lane_q == LW'(VEC_LEN - 1));
`endif

    assign capture = (state_q == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (capture) begin
            vdata_q  <= vdata;
            base_q   <= base_addr;
            stride_q <= stride;
`ifdef XVEC_VSTORE_MASK_EN
            mask_q   <= lane_mask;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Beat address/data are precomputed one cycle ahead so the bus outputs come straight from flops.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef XVEC_VSTORE_MASK_EN
                    if (lane_mask == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        lane_d  = first_idx;
                        addr_d  = lane_addr(base_addr, stride, first_idx);
                        wdata_d = lane_word(vdata, first_idx);
                    end
`else
                    state_d = S_ISSUE;
                    lane_d  = '0;
                    addr_d  = base_addr;
                    wdata_d = lane_word(vdata, '0);
`endif
                end
            end
            S_ISSUE: begin
                if (dmem.dmem_hready) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d  = next_idx;
                        addr_d  = lane_addr(base_q, stride_q, next_idx);
                        wdata_d = lane_word(vdata_q, next_idx);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign dmem.dmem_hvalid = (state_q == S_ISSUE);
    assign dmem.dmem_hwrite = (state_q == S_ISSUE);
    assign dmem.dmem_haddr  = addr_q;
    assign dmem.dmem_hwdata = wdata_q;

endmodule
